// File: rtl/power_cone_sequencer.sv
// power_cone_sequencer: walks every input vector of a combinational cone
// (binary or Gray order, N rounds) and accumulates switching activity of the
// cone output and of the applied stimulus for power estimation.
module power_cone_sequencer #(
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [7:0]        rounds,
  input  logic              abort,
  output logic [NUM_IN-1:0] vec_out,
  input  logic              cone_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  out_toggle_cnt,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [CNT_W-1:0]  in_flip_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [NUM_IN-1:0] IDX_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  // popcount of up to 8 bits fits in 4 bits, so 4 guard bits cover any add
  localparam int SUM_W = CNT_W + 4;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] idx_q, idx_d;
  logic [NUM_IN-1:0] vec_q, vec_d;
  logic [7:0]        round_q, round_d;
  logic [7:0]        rounds_q, rounds_d;
  logic              mode_q, mode_d;
  logic              seen_q, seen_d;   // a sample has been taken this run
  logic              prev_q, prev_d;   // previous cone sample
  logic [CNT_W-1:0]  tog_q, tog_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [CNT_W-1:0]  flip_q, flip_d;

  logic              last_sample;
  logic              stop_run;
  logic [NUM_IN-1:0] nxt_idx;
  logic [NUM_IN-1:0] nxt_vec;

  // index -> applied vector, binary or reflected Gray
  function automatic logic [NUM_IN-1:0] vec_of(input logic [NUM_IN-1:0] i,
                                               input logic gray);
    return gray ? (i ^ (i >> 1)) : i;
  endfunction

  function automatic logic [3:0] popcnt(input logic [NUM_IN-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int b = 0; b < NUM_IN; b++) c = c + {3'b000, v[b]};
    return c;
  endfunction

  // saturating accumulate; counters stick at all-ones
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0] inc);
    logic [SUM_W-1:0] s;
    s = {4'b0000, a} + {{CNT_W{1'b0}}, inc};
    return (s > {4'b0000, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // end-of-run detection: last index of the last requested round
  always_comb begin
    last_sample = (idx_q == IDX_MAX) &&
                  (({1'b0, round_q} + 9'd1) == {1'b0, rounds_q});
    stop_run    = last_sample || abort;
    nxt_idx     = idx_q + 1'b1;
    nxt_vec     = vec_of(nxt_idx, mode_q);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (rounds == 8'd0) ? S_DONE : S_RUN;
      S_RUN:   if (stop_run) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // datapath: stimulus stepping and activity accumulation
  always_comb begin
    idx_d    = idx_q;
    vec_d    = vec_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    mode_d   = mode_q;
    seen_d   = seen_q;
    prev_d   = prev_q;
    tog_d    = tog_q;
    ones_d   = ones_q;
    flip_d   = flip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          rounds_d = rounds;
          tog_d    = '0;
          ones_d   = '0;
          flip_d   = '0;
          idx_d    = '0;
          round_d  = '0;
          seen_d   = 1'b0;
          prev_d   = 1'b0;
          // with zero rounds nothing is applied, so vec_out keeps its value
          if (rounds != 8'd0) vec_d = vec_of('0, mode);
        end
      end
      S_RUN: begin
        if (cone_in) ones_d = sat_add(ones_q, 4'd1);
        if (seen_q && (cone_in != prev_q)) tog_d = sat_add(tog_q, 4'd1);
        seen_d = 1'b1;
        prev_d = cone_in;
        // vector only advances when the run continues; it holds at the end
        if (!stop_run) begin
          idx_d  = nxt_idx;
          vec_d  = nxt_vec;
          flip_d = sat_add(flip_q, popcnt(vec_q ^ nxt_vec));
          if (idx_q == IDX_MAX) round_d = round_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      vec_q    <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      mode_q   <= 1'b0;
      seen_q   <= 1'b0;
      prev_q   <= 1'b0;
      tog_q    <= '0;
      ones_q   <= '0;
      flip_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      mode_q   <= mode_d;
      seen_q   <= seen_d;
      prev_q   <= prev_d;
      tog_q    <= tog_d;
      ones_q   <= ones_d;
      flip_q   <= flip_d;
    end
  end

  assign vec_out        = vec_q;
  assign out_toggle_cnt = tog_q;
  assign ones_cnt       = ones_q;
  assign in_flip_cnt    = flip_q;

endmodule

// File: tb/tb_power_cone_sequencer.sv
// Bench for power_cone_sequencer: drives the reference cone from vec_out,
// compares against a list-based model of the applied vector stream.
module tb_power_cone_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, mode, abort;
  logic [7:0]  rounds;
  logic [3:0]  vec_out;
  logic        cone_in, busy, done;
  logic [15:0] tog, ones, flip;

  // second instance with narrow counters for saturation
  logic        s_start, s_mode, s_abort;
  logic [7:0]  s_rounds;
  logic [3:0]  s_vec;
  logic        s_cone, s_busy, s_done;
  logic [2:0]  s_tog, s_ones, s_flip;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [3:0] exp_seq[$];
  int exp_len, exp_ones, exp_tog, exp_flip;
  int got_ones, got_tog, got_flip;

  function automatic logic cone_f(input logic [3:0] v);
    return ~(v[0] & (v[1] | v[2])) & (v[2] ^ v[3]);
  endfunction

  assign cone_in = cone_f(vec_out);
  assign s_cone  = cone_f(s_vec);

  always #5 clk = ~clk;

  power_cone_sequencer #(.NUM_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .rounds(rounds),
    .abort(abort), .vec_out(vec_out), .cone_in(cone_in), .busy(busy),
    .done(done), .out_toggle_cnt(tog), .ones_cnt(ones), .in_flip_cnt(flip)
  );

  power_cone_sequencer #(.NUM_IN(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .rounds(s_rounds),
    .abort(s_abort), .vec_out(s_vec), .cone_in(s_cone), .busy(s_busy),
    .done(s_done), .out_toggle_cnt(s_tog), .ones_cnt(s_ones), .in_flip_cnt(s_flip)
  );

  // Expected stream: rounds x all 16 vectors, cut short by abort, then
  // activity derived from consecutive pairs of that stream.
  task automatic build_model(input bit m, input int rnd, input int ab, input int cmax);
    logic [3:0] v;
    exp_seq.delete();
    for (int r = 0; r < rnd; r++)
      for (int i = 0; i < 16; i++) begin
        v = 4'(m ? (i ^ (i >> 1)) : i);
        exp_seq.push_back(v);
      end
    if (ab > 0) while (exp_seq.size() > ab) void'(exp_seq.pop_back());
    exp_len = exp_seq.size();
    exp_ones = 0; exp_tog = 0; exp_flip = 0;
    for (int k = 0; k < exp_len; k++) begin
      if (cone_f(exp_seq[k])) exp_ones++;
      if (k > 0) begin
        if (cone_f(exp_seq[k]) != cone_f(exp_seq[k-1])) exp_tog++;
        exp_flip += $countones(exp_seq[k] ^ exp_seq[k-1]);
      end
    end
    if (exp_ones > cmax) exp_ones = cmax;
    if (exp_tog  > cmax) exp_tog  = cmax;
    if (exp_flip > cmax) exp_flip = cmax;
  endtask

  // One complete run; called at a negedge with the DUT idle, returns at the
  // negedge of the first IDLE cycle after done.
  task automatic do_run(input bit m, input int rnd, input int ab, input bit poke,
                        input string name);
    int cyc;
    build_model(m, rnd, ab, 65535);
    start = 1'b1; mode = m; rounds = 8'(rnd);
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); rounds = 8'($urandom);
    cyc = 0;
    while (busy === 1'b1 && cyc < 3000) begin
      n_checks++;
      if (cyc >= exp_len) begin
        n_fail++; $display("FAIL %s busy_len: still busy at cycle %0d, expected %0d cycles", name, cyc, exp_len);
      end else if (vec_out !== exp_seq[cyc]) begin
        n_fail++; $display("FAIL %s vec_out[%0d]: got %0h expected %0h", name, cyc, vec_out, exp_seq[cyc]);
      end
      abort = (ab > 0 && cyc + 1 == ab);
      start = poke && (cyc == 3);
      cyc++;
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (cyc != exp_len) begin
      n_fail++; $display("FAIL %s run_len: got %0d expected %0d", name, cyc, exp_len);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s done_pulse: got %b expected 1", name, done);
    end
    got_ones = ones; got_tog = tog; got_flip = flip;
    n_checks++;
    if (got_ones != exp_ones) begin
      n_fail++; $display("FAIL %s ones_cnt: got %0d expected %0d", name, got_ones, exp_ones);
    end
    n_checks++;
    if (got_tog != exp_tog) begin
      n_fail++; $display("FAIL %s out_toggle_cnt: got %0d expected %0d", name, got_tog, exp_tog);
    end
    n_checks++;
    if (got_flip != exp_flip) begin
      n_fail++; $display("FAIL %s in_flip_cnt: got %0d expected %0d", name, got_flip, exp_flip);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, done, busy);
    end
    n_checks++;
    if (ones != 16'(got_ones) || tog != 16'(got_tog) || flip != 16'(got_flip)) begin
      n_fail++; $display("FAIL %s counters_hold: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         name, ones, tog, flip, got_ones, got_tog, got_flip);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b vec=%h expected 0 0 0", busy, done, vec_out);
    end
    n_checks++;
    if (ones !== 16'd0 || tog !== 16'd0 || flip !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", ones, tog, flip);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // directed runs with the documented activity figures of the reference cone
  task automatic test_plan();
    do_run(1'b0, 1, 0, 1'b0, "bin_r1");
    n_checks++;
    if (got_ones != 5 || got_tog != 6 || got_flip != 26) begin
      n_fail++; $display("FAIL bin_r1_spec: got %0d/%0d/%0d expected 5/6/26", got_ones, got_tog, got_flip);
    end
    do_run(1'b0, 2, 0, 1'b0, "bin_r2");
    n_checks++;
    if (got_ones != 10 || got_tog != 12 || got_flip != 56) begin
      n_fail++; $display("FAIL bin_r2_spec: got %0d/%0d/%0d expected 10/12/56", got_ones, got_tog, got_flip);
    end
    do_run(1'b1, 1, 0, 1'b0, "gray_r1");
    n_checks++;
    if (got_ones != 5 || got_tog != 7 || got_flip != 15) begin
      n_fail++; $display("FAIL gray_r1_spec: got %0d/%0d/%0d expected 5/7/15", got_ones, got_tog, got_flip);
    end
    do_run(1'b1, 2, 0, 1'b0, "gray_r2");
    n_checks++;
    if (got_ones != 10 || got_tog != 15 || got_flip != 31) begin
      n_fail++; $display("FAIL gray_r2_spec: got %0d/%0d/%0d expected 10/15/31", got_ones, got_tog, got_flip);
    end
    do_run(1'b0, 0, 0, 1'b0, "zero_rounds");
    n_checks++;
    if (got_ones != 0 || got_tog != 0 || got_flip != 0) begin
      n_fail++; $display("FAIL zero_rounds_spec: got %0d/%0d/%0d expected 0/0/0", got_ones, got_tog, got_flip);
    end
    do_run(1'b0, 1, 0, 1'b1, "start_busy");
    n_checks++;
    if (got_ones != 5 || got_tog != 6 || got_flip != 26) begin
      n_fail++; $display("FAIL start_busy_spec: got %0d/%0d/%0d expected 5/6/26", got_ones, got_tog, got_flip);
    end
    do_run(1'b0, 1, 5, 1'b0, "abort5");
    n_checks++;
    if (got_ones != 1 || got_tog != 1 || got_flip != 7) begin
      n_fail++; $display("FAIL abort5_spec: got %0d/%0d/%0d expected 1/1/7", got_ones, got_tog, got_flip);
    end
    // abort coinciding with the natural end behaves like the natural end
    do_run(1'b1, 1, 16, 1'b0, "abort_at_end");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_run(1'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0,
             1'($urandom), "random");
    end
  endtask

  task automatic test_saturation();
    int cyc;
    build_model(1'b0, 4, 0, 7);
    s_start = 1'b1; s_rounds = 8'd4;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0;
    while (s_busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc != exp_len || s_done !== 1'b1) begin
      n_fail++; $display("FAIL sat_run: len %0d done %b expected %0d 1", cyc, s_done, exp_len);
    end
    n_checks++;
    if (s_ones != 3'(exp_ones) || s_tog != 3'(exp_tog) || s_flip != 3'(exp_flip)) begin
      n_fail++; $display("FAIL sat_model: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         s_ones, s_tog, s_flip, exp_ones, exp_tog, exp_flip);
    end
    n_checks++;
    if (s_ones !== 3'd7 || s_tog !== 3'd7 || s_flip !== 3'd7) begin
      n_fail++; $display("FAIL sat_spec: got %0d/%0d/%0d expected 7/7/7", s_ones, s_tog, s_flip);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_run();
    int seen_done;
    start = 1'b1; mode = 1'b1; rounds = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || vec_out === 4'h0) begin
      n_fail++; $display("FAIL rst_pre: busy=%b vec=%h expected 1 and nonzero", busy, vec_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 4'h0 ||
        ones !== 16'd0 || tog !== 16'd0 || flip !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid: busy=%b done=%b vec=%h cnt=%0d/%0d/%0d expected all 0",
                         busy, done, vec_out, ones, tog, flip);
    end
    rst = 1'b0;
    seen_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL rst_no_done: active cycles %0d expected 0", seen_done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; rounds = 8'd0; abort = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_abort = 1'b0; s_rounds = 8'd0;
    @(negedge clk);
    test_reset();
    test_plan();
    test_random();
    test_saturation();
    test_rst_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
